// File: rtl/cs_pkg.sv
// Shared types and width helpers for the windowed filter.
package cs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_SCAN,
        ST_OUT
    } cs_state_e;

    // Width that holds the sum of depth samples of dw bits without overflow.
    function automatic int cs_sum_width(input int dw, input int depth);
        return dw + $clog2(depth);
    endfunction

endpackage

// File: rtl/cs_seq_div.sv
// Restoring divider by a constant: one quotient bit per cycle, NW cycles per result.
module cs_seq_div #(
    parameter int NW      = 12,
    parameter int DIVISOR = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          start,
    input  logic [NW-1:0] num,
    output logic          done,
    output logic [NW-1:0] quot
);
    localparam int          CW    = $clog2(NW + 1);
    localparam logic [NW:0] DIV_K = (NW + 1)'(DIVISOR);

    logic [NW-1:0] rem;
    logic [CW-1:0] cnt;
    logic [NW:0]   trial;
    logic          fits;

    // Dividend bits shift out of quot's top while quotient bits fill from the bottom.
    assign trial = {rem, quot[NW-1]};
    assign fits  = (trial >= DIV_K);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem  <= '0;
            quot <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (clear) begin
            rem  <= '0;
            quot <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            quot <= num;
            cnt  <= CW'(NW);
            done <= 1'b0;
        end else if (cnt != '0) begin
            rem  <= fits ? NW'(trial - DIV_K) : trial[NW-1:0];
            quot <= {quot[NW-2:0], fits};
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1));
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/cs_window_filter.sv
// Sliding-window filter: running sum, sequential average, serial scan for the
// largest entry not above the average, optional blended approximate output.
module cs_window_filter
    import cs_pkg::*;
#(
    parameter int  DW    = 8,
    parameter int  DEPTH = 9,
    parameter int  SHIFT = 3,
    localparam int SW    = cs_sum_width(DW, DEPTH),
    localparam int OW    = SW + 1 - SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          window_full
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            FW   = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    cs_state_e     state, state_next;
    logic [DW-1:0] win [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, scan_cnt;
    logic [FW-1:0] fill;
    logic [SW-1:0] sum, sum_next, avg, quot;
    logic [DW-1:0] appro, appro_next, entry;
    logic [SW:0]   approx_full;
    logic [OW-1:0] result;
    logic          mode_q, accept, div_done;

    assign accept   = in_valid && in_ready && !clear;
    // wr_ptr always points at the oldest slot, which is overwritten on accept.
    assign sum_next = sum + SW'(in_data) - SW'(win[wr_ptr]);

    cs_seq_div #(.NW(SW), .DIVISOR(DEPTH)) u_div (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .start (accept),
        .num   (sum_next),
        .done  (div_done),
        .quot  (quot)
    );

    assign entry       = win[rd_ptr];
    assign appro_next  = (SW'(entry) <= avg && entry > appro) ? entry : appro;
    assign approx_full = (SW + 1)'(sum) + (SW + 1)'(DEPTH) * (SW + 1)'(appro_next);
    assign result      = mode_q ? approx_full[SW -: OW] : OW'(avg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == ST_IDLE);
        out_valid  = (state == ST_OUT);
        unique case (state)
            ST_IDLE: if (accept)              state_next = ST_DIV;
            ST_DIV:  if (div_done)            state_next = ST_SCAN;
            ST_SCAN: if (scan_cnt == LAST)    state_next = ST_OUT;
            ST_OUT:  if (out_ready)           state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
        if (clear) state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            scan_cnt    <= '0;
            fill        <= '0;
            sum         <= '0;
            avg         <= '0;
            appro       <= '0;
            mode_q      <= 1'b0;
            out_data    <= '0;
            window_full <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            sum         <= '0;
            window_full <= 1'b0;
        end else begin
            if (accept) begin
                win[wr_ptr] <= in_data;
                sum         <= sum_next;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                mode_q      <= mode;
                if (fill != FW'(DEPTH))     fill        <= fill + 1'b1;
                if (fill >= FW'(DEPTH - 1)) window_full <= 1'b1;
            end
            if (state == ST_DIV && div_done) begin
                avg      <= quot;
                appro    <= '0;
                rd_ptr   <= wr_ptr;
                scan_cnt <= '0;
            end
            if (state == ST_SCAN) begin
                appro    <= appro_next;
                rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                scan_cnt <= scan_cnt + 1'b1;
                // Final entry's contribution folds in via appro_next on this edge.
                if (scan_cnt == LAST) out_data <= result;
            end
        end
    end

endmodule
